fb_port_arbiter: RTL and testbench
==================================

// Module: fb_port_arbiter
// PURPOSE
// Shares one single-port framebuffer RAM between the display refresh path and the drawing
// engine. Display reads own the port whenever in_display=1; writes queue in a small FIFO
// and drain during blanking. Sits between the VGA timing generator, the framebuffer RAM and
// the pixel writer; delays sync signals to match the 1-cycle RAM read latency.
// PARAMETERS
// H_DIM       800  active pixels per line
// V_DIM       600  active lines per frame
// ADDR_W      19   RAM address width; must satisfy 2**ADDR_W >= H_DIM*V_DIM
// DATA_W      8    pixel width
// WBUF_DEPTH  4    write FIFO entries; power of 2, >= 2
// PORTS
// clk         in   1       pixel clock
// rst_n       in   1       synchronous active-low reset
// in_display  in   1       active-video flag from timing generator
// vreg        in   10      current line number from timing generator
// hs_in       in   1       hsync from timing generator (active low)
// vs_in       in   1       vsync from timing generator (active low)
// wr_valid    in   1       writer has a pixel write
// wr_ready    out  1       FIFO can accept a write (= !full)
// wr_addr     in   ADDR_W  write pixel address
// wr_data     in   DATA_W  write pixel value
// mem_addr    out  ADDR_W  RAM address
// mem_we      out  1       RAM write enable
// mem_wdata   out  DATA_W  RAM write data
// mem_rdata   in   DATA_W  RAM read data, valid 1 cycle after read address
// pix_data    out  DATA_W  pixel to DAC (0 when pix_de=0)
// pix_de      out  1       in_display delayed 1 cycle
// hs_out      out  1       hs_in delayed 1 cycle
// vs_out      out  1       vs_in delayed 1 cycle
// wr_err      out  1       sticky: a write with wr_addr >= H_DIM*V_DIM was dropped
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): FIFO empty, pix_cnt=0, state IDLE, mem_we=0, mem_addr=0,
//   pix_de=0, pix_data=0, hs_out=1, vs_out=1, wr_err=0. wr_ready=1 after reset.
//   Reset mid-drain discards all queued writes; no partial write is issued.
// - Port owner is a 3-state FSM, evaluated every cycle from current inputs:
//   READ  when in_display=1 (highest priority, unconditional)
//   WRITE when in_display=0 and FIFO not empty
//   IDLE  otherwise. No other transitions. mem_we=1 only in WRITE, so a write never
//   coincides with an in_display=1 cycle.
// - READ: mem_addr=pix_cnt, mem_we=0; pix_cnt increments, wrapping to 0 after
//   H_DIM*V_DIM-1. pix_cnt also forced to 0 on any cycle with vreg==V_DIM (frame resync).
// - WRITE: pops FIFO head; mem_addr/mem_wdata = head entry, mem_we=1; one entry per cycle.
// - IDLE: mem_we=0, mem_addr holds last value.
// - FIFO push on wr_valid && wr_ready. Full: wr_ready=0 even if a pop occurs same cycle.
//   Simultaneous push and pop when not full: both occur, count unchanged.
// - Out-of-range write (wr_addr >= H_DIM*V_DIM): handshake completes, entry not queued,
//   wr_err set until reset.
// - Latency: pix_data = mem_rdata registered path aligned so pix_data at cycle t+1
//   corresponds to in_display=1 at cycle t; pix_de/hs_out/vs_out are 1-cycle delays.
// - Address arithmetic in ADDR_W bits; H_DIM*V_DIM computed as localparam.
// TESTING
// - Reset: drive rst_n=0 mid-frame with 3 queued writes -> all outputs at reset values,
//   FIFO empty, no mem_we pulse afterwards.
// - Read sequence: line 0 active -> mem_addr 0..799; line 1 starts at 800; after line 599
//   pix_cnt=0; pix_data matches RAM model 1 cycle later with pix_de.
// - Writes during active video: 2 writes (addr 5 data 0xAA, addr 6 data 0x55) with
//   in_display=1 -> mem_we=0 throughout; both issued on first 2 blanking cycles, in order.
// - Backpressure: 5 writes during active video, WBUF_DEPTH=4 -> wr_ready=0 after 4th;
//   5th accepted on the cycle after first drain.
// - Concurrent push/pop in blanking with FIFO at 2 -> count stays 2, order preserved.
// - Out-of-range: wr_addr=480000 -> no mem_we for it, wr_err=1 until rst_n=0.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
// Shares a single-port framebuffer RAM between display refresh reads and
// drawing-engine writes. Display reads own the port whenever in_display=1.
// Writes are queued in a small FIFO and drained one per cycle during blanking.
// Sync and data-enable outputs are delayed one cycle to line up with the
// 1-cycle RAM read latency.
//
// Ports
//   clk, rst_n                 pixel clock, synchronous active-low reset
//   in_display, vreg           active-video flag and current line number
//   hs_in, vs_in               syncs from the timing generator (active low)
//   wr_valid/wr_ready          writer handshake (wr_ready = FIFO not full)
//   wr_addr, wr_data           write pixel address / value
//   mem_addr, mem_we           RAM address / write enable
//   mem_wdata, mem_rdata       RAM write data / read data (1-cycle latency)
//   pix_data, pix_de           pixel to the DAC and its data enable
//   hs_out, vs_out             syncs delayed by one cycle
//   wr_err                     sticky flag: an out-of-range write was dropped
module fb_port_arbiter #(
    parameter int H_DIM      = 800,
    parameter int V_DIM      = 600,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_display,
    input  logic [9:0]        vreg,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_de,
    output logic              hs_out,
    output logic              vs_out,
    output logic              wr_err
);

    localparam logic [ADDR_W-1:0] NPIX  = ADDR_W'(H_DIM * V_DIM);
    localparam int                PTR_W = $clog2(WBUF_DEPTH);
    localparam int                CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                hs_q, vs_q, wr_err_q;

    logic [ADDR_W-1:0]   fa_q [WBUF_DEPTH];
    logic [DATA_W-1:0]   fd_q [WBUF_DEPTH];
    logic [PTR_W-1:0]    wptr_q, rptr_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic full, empty, accept, push, pop, in_range;

    assign full     = (cnt_q == CNT_W'(WBUF_DEPTH));
    assign empty    = (cnt_q == '0);
    assign wr_ready = !full;
    assign in_range = (wr_addr < NPIX);
    assign accept   = wr_valid && wr_ready;
    assign push     = accept && in_range;
    assign pop      = (state_d == WRITE);

    // Owner is decided from the current inputs, so the RAM address and write
    // enable are combinational; the RAM's own read register provides the one
    // cycle of latency that pix_de/hs_out/vs_out are aligned to.
    always_comb begin
        state_d   = IDLE;
        mem_addr  = mem_addr_q;
        mem_we    = 1'b0;
        mem_wdata = fd_q[rptr_q];
        pix_cnt_d = pix_cnt_q;
        if (in_display)  state_d = READ;
        else if (!empty) state_d = WRITE;
        case (state_d)
            READ: begin
                mem_addr  = pix_cnt_q;
                pix_cnt_d = (pix_cnt_q == NPIX - ADDR_W'(1)) ? '0 : pix_cnt_q + ADDR_W'(1);
            end
            WRITE: begin
                mem_addr = fa_q[rptr_q];
                // Gated by reset so a drain interrupted by reset issues no write.
                mem_we   = rst_n;
            end
            default: ;
        endcase
        // Line V_DIM is the first blanking line: resync the read pointer.
        if (vreg == 10'(V_DIM)) pix_cnt_d = '0;
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pix_cnt_q  <= '0;
            mem_addr_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            mem_addr_q <= mem_addr;
            cnt_q      <= cnt_d;
            hs_q       <= hs_in;
            vs_q       <= vs_in;
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            if (accept && !in_range) wr_err_q <= 1'b1;
        end
    end

    // FIFO storage needs no reset: cnt_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fa_q[wptr_q] <= wr_addr;
            fd_q[wptr_q] <= wr_data;
        end
    end

    assign pix_de   = (state_q == READ);
    assign pix_data = pix_de ? mem_rdata : '0;
    assign hs_out   = hs_q;
    assign vs_out   = vs_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, in_display, hs_in, vs_in, wr_valid;
    logic [9:0]  vreg;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready, mem_we, pix_de, hs_out, vs_out, wr_err;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata, pix_data;

    int tests = 0;
    int failed = 0;

    logic [7:0]  ram [0:524287];
    logic [26:0] wlog [$];

    always #5 clk = ~clk;

    fb_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .in_display(in_display), .vreg(vreg),
        .hs_in(hs_in), .vs_in(vs_in), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pix_data(pix_data),
        .pix_de(pix_de), .hs_out(hs_out), .vs_out(vs_out), .wr_err(wr_err)
    );

    // Synchronous single-port RAM model plus a log of every write it receives.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            ram[mem_addr] <= mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [7:0] pat(input logic [18:0] a);
        return a[7:0] ^ {a[15:12], a[11:8]} ^ 8'h5A;
    endfunction

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int base;
        for (int a = 0; a < 524288; a++) ram[a] = pat(19'(a));
        rst_n = 0; in_display = 0; vreg = 0; hs_in = 1; vs_in = 1;
        wr_valid = 0; wr_addr = 0; wr_data = 0;
        clk1(); clk1();
        rst_n = 1;
        #1;
        chk("rst_pix_de", pix_de, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_hs_out", hs_out, 1);
        chk("rst_vs_out", vs_out, 1);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        clk1();

        // Line 0: addresses 0..799, pixels one cycle later.
        for (int i = 0; i < 800; i++) begin
            in_display = 1; vreg = 0;
            #1;
            chk("l0_addr", mem_addr, i);
            chk("l0_we", mem_we, 0);
            if (i > 0) begin
                chk("l0_pix", pix_data, pat(19'(i - 1)));
                chk("l0_de", pix_de, 1);
            end
            clk1();
        end
        in_display = 0;
        #1;
        chk("l0_last_pix", pix_data, pat(19'd799));
        chk("l0_last_de", pix_de, 1);
        clk1();
        chk("blank_de", pix_de, 0);
        chk("blank_pix", pix_data, 0);
        repeat (4) clk1();

        // Line 1 continues from 800.
        for (int i = 0; i < 800; i++) begin
            in_display = 1; vreg = 1;
            #1;
            chk("l1_addr", mem_addr, 800 + i);
            if (i > 0) chk("l1_pix", pix_data, pat(19'(799 + i)));
            clk1();
        end
        in_display = 0;
        clk1();

        // Frame resync on vreg == V_DIM.
        vreg = 600; clk1();
        vreg = 0; in_display = 1;
        #1; chk("resync_addr0", mem_addr, 0);
        clk1();
        #1; chk("resync_addr1", mem_addr, 1);
        chk("resync_pix", pix_data, pat(19'd0));
        clk1();
        in_display = 0;

        // Sync delays.
        hs_in = 0; vs_in = 0;
        #1; chk("hs_prev", hs_out, 1);
        clk1();
        hs_in = 1; vs_in = 1;
        #1; chk("hs_dly", hs_out, 0); chk("vs_dly", vs_out, 0);
        clk1();
        chk("hs_back", hs_out, 1);

        // Writes during active video wait for blanking.
        base = wlog.size();
        in_display = 1; wr_valid = 1; wr_addr = 5; wr_data = 8'hAA;
        #1; chk("wa_ready0", wr_ready, 1);
        clk1();
        wr_addr = 6; wr_data = 8'h55;
        #1; chk("wa_we_act", mem_we, 0);
        clk1();
        wr_valid = 0;
        repeat (3) clk1();
        chk("wa_no_wr_act", wlog.size(), base);
        in_display = 0;
        #1; chk("wa_we0", mem_we, 1); chk("wa_addr0", mem_addr, 5); chk("wa_data0", mem_wdata, 8'hAA);
        clk1();
        #1; chk("wa_we1", mem_we, 1); chk("wa_addr1", mem_addr, 6); chk("wa_data1", mem_wdata, 8'h55);
        clk1();
        #1; chk("wa_idle_we", mem_we, 0); chk("wa_idle_hold", mem_addr, 6);
        chk("wa_count", wlog.size(), base + 2);
        clk1();

        // Backpressure: FIFO of 4, fifth write waits for the first drain.
        base = wlog.size();
        in_display = 1; wr_valid = 1;
        for (int k = 0; k < 5; k++) begin
            wr_addr = 19'(100 + k); wr_data = 8'(k + 1);
            #1; chk("bp_ready", wr_ready, (k < 4) ? 1 : 0);
            clk1();
        end
        in_display = 0;
        #1; chk("bp_full_pop_ready", wr_ready, 0); chk("bp_d0", mem_addr, 100);
        clk1();
        #1; chk("bp_ready_after", wr_ready, 1); chk("bp_d1", mem_addr, 101);
        clk1();
        wr_valid = 0;
        for (int k = 2; k < 5; k++) begin
            #1; chk("bp_drain_we", mem_we, 1); chk("bp_drain", mem_addr, 100 + k);
            clk1();
        end
        #1; chk("bp_done_we", mem_we, 0);
        chk("bp_count", wlog.size(), base + 5);
        chk("bp_last", wlog[base + 4], {19'd104, 8'd5});
        clk1();

        // Concurrent push/pop with two queued entries.
        base = wlog.size();
        in_display = 1; wr_valid = 1;
        wr_addr = 200; wr_data = 8'hC0; clk1();
        wr_addr = 201; wr_data = 8'hC1; clk1();
        in_display = 0;
        wr_addr = 202; wr_data = 8'hC2;
        #1; chk("pp_a0", mem_addr, 200); chk("pp_ready0", wr_ready, 1);
        clk1();
        wr_addr = 203; wr_data = 8'hC3;
        #1; chk("pp_a1", mem_addr, 201);
        clk1();
        wr_valid = 0;
        #1; chk("pp_a2", mem_addr, 202); chk("pp_d2", mem_wdata, 8'hC2);
        clk1();
        #1; chk("pp_a3", mem_addr, 203); chk("pp_d3", mem_wdata, 8'hC3);
        clk1();
        #1; chk("pp_empty", mem_we, 0);
        chk("pp_count", wlog.size(), base + 4);

        // Out-of-range write is dropped and flagged; last valid address is kept.
        base = wlog.size();
        wr_valid = 1; wr_addr = 480000; wr_data = 8'h77;
        #1; chk("oor_ready", wr_ready, 1);
        clk1();
        wr_addr = 479999; wr_data = 8'h78;
        #1; chk("oor_no_we", mem_we, 0); chk("oor_err", wr_err, 1);
        clk1();
        wr_valid = 0;
        #1; chk("edge_we", mem_we, 1); chk("edge_addr", mem_addr, 479999);
        clk1();
        repeat (3) clk1();
        chk("oor_err_sticky", wr_err, 1);
        chk("oor_count", wlog.size(), base + 1);

        // Reset with three queued writes.
        in_display = 1; vreg = 3; wr_valid = 1;
        for (int k = 0; k < 3; k++) begin
            wr_addr = 19'(300 + k); wr_data = 8'(k); clk1();
        end
        wr_valid = 0;
        base = wlog.size();
        in_display = 0; rst_n = 0; hs_in = 0; vs_in = 0;
        #1; chk("rst_drain_we", mem_we, 0);
        clk1();
        rst_n = 1; hs_in = 1; vs_in = 1;
        #1;
        chk("rst2_we", mem_we, 0);
        chk("rst2_addr", mem_addr, 0);
        chk("rst2_ready", wr_ready, 1);
        chk("rst2_de", pix_de, 0);
        chk("rst2_pix", pix_data, 0);
        chk("rst2_hs", hs_out, 1);
        chk("rst2_vs", vs_out, 1);
        chk("rst2_err", wr_err, 0);
        repeat (5) clk1();
        chk("rst2_no_writes", wlog.size(), base);
        in_display = 1;
        #1; chk("rst2_pixcnt", mem_addr, 0);
        clk1();
        in_display = 0;
        clk1();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
